// File: rtl/nes_pkg.sv
// Shared definitions for the cpumc bus arbiter: state encoding,
// requester IDs, idle-bus address and stall counter width.
package nes_pkg;

    typedef enum logic [1:0] {
        S_CPU  = 2'd0,
        S_HAND = 2'd1,
        S_DMA  = 2'd2,
        S_DBG  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REQ_CPU = 2'd0,
        REQ_DMA = 2'd1,
        REQ_DBG = 2'd2
    } req_id_t;

    // Turnaround address: a WRAM read with no side effects.
    localparam logic [15:0] IDLE_A_DEF  = 16'h0000;
    localparam int          STALL_W_DEF = 16;

    // Fixed priority: debugger over DMA over CPU.
    function automatic req_id_t pick_owner(input logic dbg_req, input logic dma_req);
        if (dbg_req)
            return REQ_DBG;
        else if (dma_req)
            return REQ_DMA;
        else
            return REQ_CPU;
    endfunction

endpackage

// File: rtl/cpumc_arb_stall_ctr.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module stall_ctr #(
    parameter int W = 16
) (
    input  logic         clk_in,
    input  logic         nrst_in,
    input  logic         clr_in,
    input  logic         en_in,
    output logic [W-1:0] cnt_out
);

    logic [W-1:0] cnt_reg;

    // Count enabled cycles, hold at all-ones, clear has priority.
    always_ff @(posedge clk_in) begin
        if (!nrst_in)
            cnt_reg <= '0;
        else if (clr_in)
            cnt_reg <= '0;
        else if (en_in && (cnt_reg != '1))
            cnt_reg <= cnt_reg + 1'b1;
    end

    assign cnt_out = cnt_reg;

endmodule

// File: rtl/cpumc_arb.sv
// CPU memory bus arbiter: CPU is the default owner, sprite DMA and the
// serial debugger request the bus. Every owner change passes through one
// idle turnaround cycle; CPU write cycles are never interrupted.
module cpumc_arb
    import nes_pkg::*;
#(
    parameter logic [15:0] IDLE_A  = IDLE_A_DEF,
    parameter int          STALL_W = STALL_W_DEF
) (
    input  logic               clk_in,
    input  logic               nrst_in,
    input  logic [15:0]        cpu_a_in,
    input  logic               cpu_r_nw_in,
    input  logic [7:0]         cpu_d_in,
    input  logic               dma_req_in,
    input  logic [15:0]        dma_a_in,
    input  logic               dma_r_nw_in,
    input  logic [7:0]         dma_d_in,
    input  logic               dbg_req_in,
    input  logic [15:0]        dbg_a_in,
    input  logic               dbg_r_nw_in,
    input  logic [7:0]         dbg_d_in,
    input  logic               stall_clr_in,
    output logic               dma_gnt_out,
    output logic               dbg_gnt_out,
    output logic               cpu_ready_out,
    output logic [15:0]        cpumc_a_out,
    output logic               cpumc_r_nw_out,
    output logic [7:0]         cpumc_d_out,
    output logic [STALL_W-1:0] stall_cnt_out
);

    state_t  state_reg;
    req_id_t tgt_reg;
    req_id_t next_owner;
    logic    cpu_ready_reg;
    logic    dma_gnt_reg;
    logic    dbg_gnt_reg;

    assign next_owner = pick_owner(dbg_req_in, dma_req_in);

    // Ownership FSM; the handshake outputs are registered alongside the state.
    always_ff @(posedge clk_in) begin
        if (!nrst_in) begin
            state_reg     <= S_CPU;
            tgt_reg       <= REQ_CPU;
            cpu_ready_reg <= 1'b1;
            dma_gnt_reg   <= 1'b0;
            dbg_gnt_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_CPU: begin
                    // Only leave on a read cycle so a write sequence completes.
                    if ((dbg_req_in || dma_req_in) && cpu_r_nw_in) begin
                        state_reg     <= S_HAND;
                        cpu_ready_reg <= 1'b0;
                    end
                end
                S_DMA: begin
                    // DMA yields on release or when the debugger asks.
                    if (!dma_req_in || dbg_req_in) begin
                        state_reg   <= S_HAND;
                        dma_gnt_reg <= 1'b0;
                    end
                end
                S_DBG: begin
                    if (!dbg_req_in) begin
                        state_reg   <= S_HAND;
                        dbg_gnt_reg <= 1'b0;
                    end
                end
                S_HAND: begin
                    // Priority is re-evaluated from the live requests.
                    tgt_reg <= next_owner;
                    case (next_owner)
                        REQ_DBG: begin
                            state_reg   <= S_DBG;
                            dbg_gnt_reg <= 1'b1;
                        end
                        REQ_DMA: begin
                            state_reg   <= S_DMA;
                            dma_gnt_reg <= 1'b1;
                        end
                        default: begin
                            state_reg     <= S_CPU;
                            cpu_ready_reg <= 1'b1;
                        end
                    endcase
                end
                default: begin
                    state_reg     <= S_CPU;
                    tgt_reg       <= REQ_CPU;
                    cpu_ready_reg <= 1'b1;
                    dma_gnt_reg   <= 1'b0;
                    dbg_gnt_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ready_out = cpu_ready_reg;
    assign dma_gnt_out   = dma_gnt_reg;
    assign dbg_gnt_out   = dbg_gnt_reg;

    // Bus mux: owner passthrough, or a harmless read during turnaround.
    always_comb begin
        cpumc_a_out    = cpu_a_in;
        cpumc_r_nw_out = cpu_r_nw_in;
        cpumc_d_out    = cpu_d_in;
        if (state_reg == S_HAND) begin
            cpumc_a_out    = IDLE_A;
            cpumc_r_nw_out = 1'b1;
            cpumc_d_out    = 8'h00;
        end else begin
            case (tgt_reg)
                REQ_DMA: begin
                    cpumc_a_out    = dma_a_in;
                    cpumc_r_nw_out = dma_r_nw_in;
                    cpumc_d_out    = dma_d_in;
                end
                REQ_DBG: begin
                    cpumc_a_out    = dbg_a_in;
                    cpumc_r_nw_out = dbg_r_nw_in;
                    cpumc_d_out    = dbg_d_in;
                end
                default: ;
            endcase
        end
    end

    stall_ctr #(
        .W(STALL_W)
    ) u_stall_ctr (
        .clk_in  (clk_in),
        .nrst_in (nrst_in),
        .clr_in  (stall_clr_in),
        .en_in   (!cpu_ready_reg),
        .cnt_out (stall_cnt_out)
    );

endmodule
